// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus port among NUM_REQ cache-side masters.
// The grant is held for a whole burst; a watchdog flags a burst that never ends.
package cbus_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strobe_t;
    typedef logic [2:0]  msize_t;
    typedef logic [3:0]  mlen_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
        mlen_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  cbus_req_t                  ireqs [NUM_REQ],
    output cbus_resp_t                 iresps [NUM_REQ],
    output cbus_req_t                  oreq,
    input  cbus_resp_t                 oresp,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       err_timeout
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] prio_ptr, prio_next;
    logic [IW-1:0] grant_next;
    logic [WW-1:0] wdog, wdog_next;
    logic          err_next;
    logic          found;
    logic          done;
    logic [IW:0]   cand;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (v == IW'(NUM_REQ - 1)) return '0;
        else return v + 1'b1;
    endfunction

    always_comb begin
        state_next = state;
        prio_next  = prio_ptr;
        grant_next = grant_idx;
        wdog_next  = wdog;
        err_next   = err_timeout;
        found      = 1'b0;
        cand       = '0;
        oreq       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
        end
        done = oresp.ready & oresp.last;

        unique case (state)
            IDLE: begin
                // Scan starts at prio_ptr and wraps by subtraction so any NUM_REQ works.
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand = {1'b0, prio_ptr} + (IW+1)'(k);
                    if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
                    if (!found && ireqs[cand[IW-1:0]].valid) begin
                        found      = 1'b1;
                        grant_next = cand[IW-1:0];
                    end
                end
                if (found) begin
                    state_next = BUSY;
                    wdog_next  = '0;
                end
            end
            BUSY: begin
                oreq              = ireqs[grant_idx];
                iresps[grant_idx] = oresp;
                if (done) begin
                    state_next = IDLE;
                    prio_next  = wrap_inc(grant_idx);
                end
                if (wdog != WW'(TIMEOUT)) wdog_next = wdog + 1'b1;
                if ((TIMEOUT != 0) && !done && (wdog == WW'(TIMEOUT - 1))) err_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prio_ptr    <= '0;
            grant_idx   <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            prio_ptr    <= prio_next;
            grant_idx   <= grant_next;
            wdog        <= wdog_next;
            err_timeout <= err_next;
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboard bench for cbus_rr_arbiter: expected grants are queued as requests are
// driven and checked when the arbiter starts each transaction on oreq.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    typedef struct {
        int          grant;
        logic [31:0] addr;
        int          beats;
    } exp_t;

    logic       clk;
    logic       reset;
    cbus_req_t  ireqs [2];
    cbus_resp_t iresps [2];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [0:0] grant_idx;
    logic       err_timeout;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t cur;
    int   done_cnt [2] = '{0, 0};
    int   seen [2] = '{0, 0};
    int   rem [2] = '{0, 0};
    int   beat = 0;
    int   nbeats = 0;
    int   gap = 0;
    bit   in_txn = 0;
    bit   have_prev = 0;
    bit   mem_nolast = 0;

    cbus_rr_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
        .oreq(oreq), .oresp(oresp), .busy(busy), .grant_idx(grant_idx),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic cbus_req_t mk_req(input logic v, input logic [31:0] a, input logic [3:0] len);
        cbus_req_t r;
        r = '0;
        r.valid = v;
        r.size  = 3'd2;
        r.addr  = a;
        r.len   = len;
        return r;
    endfunction

    task automatic push_exp(input int g, input logic [31:0] a, input int b);
        exp_t e;
        e.grant = g;
        e.addr  = a;
        e.beats = b;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: ready on every valid cycle, last once len+1 beats have been served.
    always_comb begin
        oresp       = '0;
        oresp.ready = oreq.valid;
        oresp.last  = oresp.ready && !mem_nolast && (beat >= int'(oreq.len));
        oresp.data  = 32'hD000_0000 | beat[31:0];
    end

    always @(posedge clk) begin
        if (reset) beat <= 0;
        else if (oresp.ready && oresp.last) beat <= 0;
        else if (oresp.ready) beat <= beat + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            in_txn    = 0;
            have_prev = 0;
            gap       = 0;
        end else if (busy) begin
            if (!in_txn && oreq.valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    check_eq("grant_idx", grant_idx, cur.grant);
                    if (have_prev) check_eq("bubble", gap, 1);
                    in_txn = 1;
                    nbeats = 0;
                end
            end
            if (in_txn) begin
                if (oreq.valid) check_eq("oreq_addr", oreq.addr, cur.addr);
                check_eq("resp_pass", iresps[cur.grant], oresp);
                for (int i = 0; i < 2; i++)
                    if (i != cur.grant) check_eq("nongrant_ready", iresps[i].ready, 0);
                if (oresp.ready) nbeats++;
                if (oresp.ready && oresp.last) begin
                    if (cur.beats >= 0) check_eq("beats", nbeats, cur.beats);
                    done_cnt[cur.grant]++;
                    in_txn    = 0;
                    have_prev = 1;
                    gap       = 0;
                end
            end
        end else begin
            gap++;
            check_eq("idle_oreq_valid", oreq.valid, 0);
            for (int i = 0; i < 2; i++) check_eq("idle_ready", iresps[i].ready, 0);
        end
    end

    task automatic run_until(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            tick();
            cyc++;
            for (int i = 0; i < 2; i++) begin
                while (seen[i] != done_cnt[i]) begin
                    seen[i]++;
                    got++;
                    if (rem[i] > 0) rem[i]--;
                    if (rem[i] == 0) ireqs[i].valid = 1'b0;
                end
            end
        end
        check_eq("run_done", got, n);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ireqs[0]   = '0;
        ireqs[1]   = '0;
        mem_nolast = 0;
        tick();
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant_idx, 0);
        check_eq("rst_err", err_timeout, 0);
        check_eq("rst_oreq", oreq, '0);
        check_eq("rst_iresp0", iresps[0], '0);
        check_eq("rst_iresp1", iresps[1], '0);
        reset = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 2; i++) begin
            seen[i] = done_cnt[i];
            rem[i]  = 0;
        end
    endtask

    initial begin
        reset    = 1'b1;
        ireqs[0] = '0;
        ireqs[1] = '0;

        // Single 4-beat read from master 1
        do_reset();
        ireqs[1] = mk_req(1'b1, 32'h1000_0040, 4'd3);
        rem[1]   = 1;
        push_exp(1, 32'h1000_0040, 4);
        #1 check_eq("t1_latency", oreq.valid, 0);
        run_until(1, 50);
        check_eq("t1_idle", busy, 0);
        check_eq("t1_sb_empty", sb_q.size(), 0);

        // Simultaneous requests: 0 first, then 1
        do_reset();
        ireqs[0] = mk_req(1'b1, 32'h2000_0000, 4'd0);
        ireqs[1] = mk_req(1'b1, 32'h2100_0000, 4'd1);
        rem[0]   = 1;
        rem[1]   = 1;
        push_exp(0, 32'h2000_0000, 1);
        push_exp(1, 32'h2100_0000, 2);
        run_until(2, 50);
        check_eq("t2_prio_ptr", dut.prio_ptr, 0);
        check_eq("t2_sb_empty", sb_q.size(), 0);

        // Continuous contention, single-beat transactions
        do_reset();
        ireqs[0] = mk_req(1'b1, 32'h3000_0000, 4'd0);
        ireqs[1] = mk_req(1'b1, 32'h3100_0000, 4'd0);
        rem[0]   = 3;
        rem[1]   = 3;
        for (int k = 0; k < 6; k++) push_exp(k % 2, (k % 2 == 0) ? 32'h3000_0000 : 32'h3100_0000, 1);
        run_until(6, 100);
        check_eq("t3_sb_empty", sb_q.size(), 0);

        // Lock: master 1 arrives at beat 2 of master 0's 8-beat burst
        do_reset();
        ireqs[0] = mk_req(1'b1, 32'h4000_0000, 4'd7);
        rem[0]   = 1;
        push_exp(0, 32'h4000_0000, 8);
        tick();
        tick();
        tick();
        ireqs[1] = mk_req(1'b1, 32'h4100_0000, 4'd0);
        rem[1]   = 1;
        push_exp(1, 32'h4100_0000, 1);
        run_until(2, 50);
        check_eq("t4_sb_empty", sb_q.size(), 0);

        // Watchdog with TIMEOUT=16: memory withholds last
        do_reset();
        ireqs[0]   = mk_req(1'b1, 32'h5000_0000, 4'd0);
        rem[0]     = 1;
        mem_nolast = 1;
        push_exp(0, 32'h5000_0000, -1);
        tick();
        check_eq("t5_busy", busy, 1);
        repeat (15) tick();
        check_eq("t5_err_before", err_timeout, 0);
        tick();
        check_eq("t5_err_set", err_timeout, 1);
        repeat (3) tick();
        check_eq("t5_err_sticky", err_timeout, 1);
        mem_nolast = 0;
        run_until(1, 20);
        check_eq("t5_err_after_done", err_timeout, 1);
        check_eq("t5_idle", busy, 0);
        do_reset();
        check_eq("t5_err_cleared", err_timeout, 0);

        // Reset at beat 2 of a 4-beat burst from master 1
        ireqs[1] = mk_req(1'b1, 32'h6000_0000, 4'd3);
        rem[1]   = 1;
        push_exp(1, 32'h6000_0000, 4);
        tick();
        check_eq("t6_grant_before", grant_idx, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("t6_busy", busy, 0);
        check_eq("t6_grant", grant_idx, 0);
        check_eq("t6_err", err_timeout, 0);
        check_eq("t6_oreq", oreq, '0);
        check_eq("t6_sb_empty", sb_q.size(), 0);
        ireqs[1] = '0;
        reset    = 1'b0;
        tick();
        check_eq("t6_stay_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
